// File: rtl/kmc_obus_pkg.sv
// kmc_obus shared definitions: destination address maps
// for both OBUS spaces and NPRC bit positions.
package kmc_obus_pkg;

  localparam logic SP_OBUS  = 1'b0;
  localparam logic SP_OBUSS = 1'b1;

  localparam logic [3:0] O_NPRID_L = 4'd0;
  localparam logic [3:0] O_NPRID_H = 4'd1;
  localparam logic [3:0] O_NPROD_L = 4'd2;
  localparam logic [3:0] O_NPROD_H = 4'd3;
  localparam logic [3:0] O_NPRIA_L = 4'd4;
  localparam logic [3:0] O_NPRIA_H = 4'd5;
  localparam logic [3:0] O_NPROA_L = 4'd6;
  localparam logic [3:0] O_NPROA_H = 4'd7;
  localparam logic [3:0] O_XREG0   = 4'd8;

  localparam logic [3:0] S_CSR0_L = 4'd0;
  localparam logic [3:0] S_CSR6_H = 4'd7;
  localparam logic [3:0] S_NPRC   = 4'd8;
  localparam logic [3:0] S_MISC   = 4'd9;

  localparam int NPRC_REQ   = 0;
  localparam int NPRC_DIR   = 1;
  localparam int NPRC_XA_LO = 2;
  localparam int NPRC_XA_HI = 3;
  localparam int NPRC_NXM   = 7;

  function automatic logic [1:0] lane_en(
    input logic       wr,
    input logic [1:0] addr,
    input logic [1:0] be,
    input logic [1:0] word
  );
    return (wr && addr == word) ? be : 2'b00;
  endfunction

endpackage

// File: rtl/kmc_obus_if.sv
// Unibus slave CSR write port of kmc_obus.
// Master drives the bus side, slave is the register file.
interface kmc_obus_if;
  logic        busWR;
  logic [1:0]  busADDR;
  logic [1:0]  busBE;
  logic [15:0] busDATA;

  modport master (
    output busWR, busADDR, busBE, busDATA
  );
  modport slave (
    input busWR, busADDR, busBE, busDATA
  );
endinterface

// File: rtl/kmc_byte_reg.sv
// 16-bit register, two byte lanes, each with a microcode
// port and a Unibus port; the Unibus wins per lane.
module kmc_byte_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  uwe,
  input  logic [7:0]  udata,
  input  logic [1:0]  bwe,
  input  logic [15:0] bdata,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bwe[i])
          q[i*8 +: 8] <= bdata[i*8 +: 8];
        else if (uwe[i])
          q[i*8 +: 8] <= udata;
      end
    end
  end

endmodule

// File: rtl/kmc_obus.sv
// KMC11 destination register file: NPR regs, CSRs,
// NPRC/MISC, LUI strobe and the NPR request handshake.
module kmc_obus
  import kmc_obus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        obusWE,
  input  logic        obusSPACE,
  input  logic [3:0]  obusADDR,
  input  logic [7:0]  obusDATA,
  kmc_obus_if.slave   bus,
  input  logic        dmaDONE,
  input  logic        dmaNXM,
  input  logic [15:0] dmaRDATA,
  output logic [15:0] kmcNPRID,
  output logic [15:0] kmcNPROD,
  output logic [15:0] kmcNPRIA,
  output logic [15:0] kmcNPROA,
  output logic [15:0] kmcCSR0,
  output logic [15:0] kmcCSR2,
  output logic [15:0] kmcCSR4,
  output logic [15:0] kmcCSR6,
  output logic [7:0]  kmcNPRC,
  output logic [7:0]  kmcMISC,
  output logic        luiWR,
  output logic [2:0]  luiADDR,
  output logic [7:0]  luiDATA,
  output logic        dmaREQ
);

  logic [7:0]  npr_we;
  logic [7:0]  csr_we;
  logic        nprc_we;
  logic        misc_we;
  logic        xreg_we;
  logic [15:0] npr [4];
  logic [15:0] csr [4];
  logic        rd_load;

  always_comb begin
    npr_we  = '0;
    csr_we  = '0;
    nprc_we = 1'b0;
    misc_we = 1'b0;
    xreg_we = 1'b0;
    if (obusWE) begin
      unique case (1'b1)
        obusSPACE == SP_OBUS && !obusADDR[3]:
          npr_we[obusADDR[2:0]] = 1'b1;
        obusSPACE == SP_OBUS && obusADDR[3]:
          xreg_we = 1'b1;
        obusSPACE == SP_OBUSS && !obusADDR[3]:
          csr_we[obusADDR[2:0]] = 1'b1;
        obusSPACE == SP_OBUSS && obusADDR == S_NPRC:
          nprc_we = 1'b1;
        obusSPACE == SP_OBUSS && obusADDR == S_MISC:
          misc_we = 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_csr
    kmc_byte_reg u_csr (
      .clk   (clk),
      .rst_n (rst_n),
      .uwe   (csr_we[2*k +: 2]),
      .udata (obusDATA),
      .bwe   (lane_en(bus.busWR, bus.busADDR,
                      bus.busBE, 2'(k))),
      .bdata (bus.busDATA),
      .q     (csr[k])
    );
  end

  // A completed read overrides any same-cycle microcode write
  assign rd_load = dmaDONE && !kmcNPRC[NPRC_DIR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        npr[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        for (int b = 0; b < 2; b++)
          if (npr_we[2*i+b])
            npr[i][b*8 +: 8] <= obusDATA;
      if (rd_load)
        npr[0] <= dmaRDATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kmcNPRC <= '0;
    end else if (nprc_we) begin
      kmcNPRC <= obusDATA;
    end else if (dmaNXM) begin
      kmcNPRC[NPRC_REQ] <= 1'b0;
      kmcNPRC[NPRC_NXM] <= 1'b1;
    end else if (dmaDONE) begin
      kmcNPRC[NPRC_REQ] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      kmcMISC <= '0;
    else if (misc_we)
      kmcMISC <= obusDATA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luiWR   <= 1'b0;
      luiADDR <= '0;
      luiDATA <= '0;
    end else begin
      luiWR <= xreg_we;
      if (xreg_we) begin
        luiADDR <= obusADDR[2:0];
        luiDATA <= obusDATA;
      end
    end
  end

  assign kmcNPRID = npr[0];
  assign kmcNPROD = npr[1];
  assign kmcNPRIA = npr[2];
  assign kmcNPROA = npr[3];
  assign kmcCSR0  = csr[0];
  assign kmcCSR2  = csr[1];
  assign kmcCSR4  = csr[2];
  assign kmcCSR6  = csr[3];
  assign dmaREQ   = kmcNPRC[NPRC_REQ];

endmodule

// File: tb/tb_kmc_obus.sv
// Self-checking bench for kmc_obus: directed vector table,
// multi-cycle corner sequences and randomized model check.
module tb_kmc_obus;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        obusWE, obusSPACE;
  logic [3:0]  obusADDR;
  logic [7:0]  obusDATA;
  logic        dmaDONE, dmaNXM;
  logic [15:0] dmaRDATA;
  logic [15:0] kmcNPRID, kmcNPROD, kmcNPRIA, kmcNPROA;
  logic [15:0] kmcCSR0, kmcCSR2, kmcCSR4, kmcCSR6;
  logic [7:0]  kmcNPRC, kmcMISC;
  logic        luiWR;
  logic [2:0]  luiADDR;
  logic [7:0]  luiDATA;
  logic        dmaREQ;

  kmc_obus_if ifc ();

  kmc_obus dut (
    .clk(clk), .rst_n(rst_n),
    .obusWE(obusWE), .obusSPACE(obusSPACE),
    .obusADDR(obusADDR), .obusDATA(obusDATA),
    .bus(ifc.slave),
    .dmaDONE(dmaDONE), .dmaNXM(dmaNXM),
    .dmaRDATA(dmaRDATA),
    .kmcNPRID(kmcNPRID), .kmcNPROD(kmcNPROD),
    .kmcNPRIA(kmcNPRIA), .kmcNPROA(kmcNPROA),
    .kmcCSR0(kmcCSR0), .kmcCSR2(kmcCSR2),
    .kmcCSR4(kmcCSR4), .kmcCSR6(kmcCSR6),
    .kmcNPRC(kmcNPRC), .kmcMISC(kmcMISC),
    .luiWR(luiWR), .luiADDR(luiADDR),
    .luiDATA(luiDATA), .dmaREQ(dmaREQ)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // reference model: registers as plain byte arrays
  logic [7:0] m_csr [8];
  logic [7:0] m_npr [8];
  logic [7:0] m_nprc, m_misc, m_luid;
  logic       m_luiwr;
  logic [2:0] m_luia;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_csr[i] = 8'h00;
      m_npr[i] = 8'h00;
    end
    m_nprc = 0; m_misc = 0; m_luid = 0;
    m_luiwr = 0; m_luia = 0;
  endtask

  task automatic model_step();
    logic [7:0] old_nprc;
    logic       nprc_written;
    int         a;
    old_nprc = m_nprc;
    nprc_written = 0;
    a = int'(obusADDR);
    m_luiwr = 0;
    if (obusWE && !obusSPACE) begin
      if (a < 8) m_npr[a] = obusDATA;
      else begin
        m_luiwr = 1;
        m_luia = 3'(a - 8);
        m_luid = obusDATA;
      end
    end
    if (obusWE && obusSPACE) begin
      if (a < 8) begin
        if (!(ifc.busWR && int'(ifc.busADDR) == a / 2
              && ifc.busBE[a % 2]))
          m_csr[a] = obusDATA;
      end else if (a == 8) begin
        m_nprc = obusDATA;
        nprc_written = 1;
      end else if (a == 9) begin
        m_misc = obusDATA;
      end
    end
    if (ifc.busWR) begin
      if (ifc.busBE[0])
        m_csr[2*ifc.busADDR] = ifc.busDATA[7:0];
      if (ifc.busBE[1])
        m_csr[2*ifc.busADDR+1] = ifc.busDATA[15:8];
    end
    if (!nprc_written) begin
      if (dmaNXM) begin
        m_nprc[0] = 0;
        m_nprc[7] = 1;
      end else if (dmaDONE) begin
        m_nprc[0] = 0;
      end
    end
    if (dmaDONE && !old_nprc[1]) begin
      m_npr[0] = dmaRDATA[7:0];
      m_npr[1] = dmaRDATA[15:8];
    end
  endtask

  task automatic check_all();
    chk("csr0", kmcCSR0, {m_csr[1], m_csr[0]});
    chk("csr2", kmcCSR2, {m_csr[3], m_csr[2]});
    chk("csr4", kmcCSR4, {m_csr[5], m_csr[4]});
    chk("csr6", kmcCSR6, {m_csr[7], m_csr[6]});
    chk("nprid", kmcNPRID, {m_npr[1], m_npr[0]});
    chk("nprod", kmcNPROD, {m_npr[3], m_npr[2]});
    chk("npria", kmcNPRIA, {m_npr[5], m_npr[4]});
    chk("nproa", kmcNPROA, {m_npr[7], m_npr[6]});
    chk("nprc", {8'h0, kmcNPRC}, {8'h0, m_nprc});
    chk("misc", {8'h0, kmcMISC}, {8'h0, m_misc});
    chk("dmareq", {15'h0, dmaREQ}, {15'h0, m_nprc[0]});
    chk("luiwr", {15'h0, luiWR}, {15'h0, m_luiwr});
    chk("luiaddr", {13'h0, luiADDR}, {13'h0, m_luia});
    chk("luidata", {8'h0, luiDATA}, {8'h0, m_luid});
  endtask

  task automatic idle();
    obusWE = 0; obusSPACE = 0; obusADDR = 0; obusDATA = 0;
    ifc.busWR = 0; ifc.busADDR = 0; ifc.busBE = 0;
    ifc.busDATA = 0;
    dmaDONE = 0; dmaNXM = 0; dmaRDATA = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  typedef struct {
    logic        we;
    logic        sp;
    logic [3:0]  a;
    logic [7:0]  d;
    logic        bw;
    logic [1:0]  ba;
    logic [1:0]  be;
    logic [15:0] bd;
    logic        done;
    logic        nxm;
    logic [15:0] rd;
    int          sel;
    logic [15:0] exp;
  } vec_t;

  localparam int S_CSR0 = 0, S_CSR2 = 1, S_NPRID = 2,
                 S_NPRC = 3, S_REQ = 4, S_LUI = 5,
                 S_MISC = 6;

  function automatic logic [15:0] get_out(input int sel);
    case (sel)
      S_CSR0:  return kmcCSR0;
      S_CSR2:  return kmcCSR2;
      S_NPRID: return kmcNPRID;
      S_NPRC:  return {8'h0, kmcNPRC};
      S_REQ:   return {15'h0, dmaREQ};
      S_LUI:   return {4'h0, luiWR, luiADDR, luiDATA};
      default: return {8'h0, kmcMISC};
    endcase
  endfunction

  function automatic vec_t mk(
    input logic we, input logic sp, input logic [3:0] a,
    input logic [7:0] d, input logic bw,
    input logic [1:0] ba, input logic [1:0] be,
    input logic [15:0] bd, input logic done,
    input logic nxm, input logic [15:0] rd,
    input int sel, input logic [15:0] exp);
    vec_t v;
    v.we = we; v.sp = sp; v.a = a; v.d = d;
    v.bw = bw; v.ba = ba; v.be = be; v.bd = bd;
    v.done = done; v.nxm = nxm; v.rd = rd;
    v.sel = sel; v.exp = exp;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    tbl[0]  = mk(1,1,3,8'hA5,0,0,0,0,0,0,0,S_CSR2,16'hA500);
    tbl[1]  = mk(1,1,0,8'h11,1,0,2'b01,16'h2233,0,0,0,
                 S_CSR0,16'h0033);
    tbl[2]  = mk(1,1,0,8'h11,1,0,2'b10,16'h2233,0,0,0,
                 S_CSR0,16'h2211);
    tbl[3]  = mk(1,1,8,8'h01,0,0,0,0,0,0,0,S_REQ,16'h1);
    tbl[4]  = mk(0,0,0,0,0,0,0,0,1,0,16'hBEEF,
                 S_NPRID,16'hBEEF);
    tbl[5]  = mk(0,0,0,0,0,0,0,0,0,0,0,S_REQ,16'h0);
    tbl[6]  = mk(1,1,8,8'h01,0,0,0,0,0,0,0,S_REQ,16'h1);
    tbl[7]  = mk(1,1,8,8'h03,0,0,0,0,0,1,0,S_NPRC,16'h03);
    tbl[8]  = mk(0,0,0,0,0,0,0,0,0,0,0,S_REQ,16'h1);
    tbl[9]  = mk(0,0,0,0,0,0,0,0,0,1,0,S_NPRC,16'h82);
    tbl[10] = mk(1,0,13,8'h5C,0,0,0,0,0,0,0,S_LUI,16'h0D5C);
    tbl[11] = mk(0,0,0,0,0,0,0,0,0,0,0,S_LUI,16'h055C);
    tbl[12] = mk(1,1,9,8'h12,0,0,0,0,0,0,0,S_MISC,16'h12);
    tbl[13] = mk(1,1,9,8'h34,0,0,0,0,0,0,0,S_MISC,16'h34);
    tbl[14] = mk(1,0,1,8'hAB,0,0,0,0,0,0,0,
                 S_NPRID,16'hABEF);
    tbl[15] = mk(0,0,0,0,0,0,0,0,1,0,16'h1234,
                 S_NPRID,16'hABEF);
    tbl[16] = mk(1,1,8,8'h00,0,0,0,0,0,0,0,S_NPRC,16'h00);
    tbl[17] = mk(1,0,0,8'h77,0,0,0,0,1,0,16'h5555,
                 S_NPRID,16'h5555);

    idle();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    #10 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      obusWE = tbl[i].we; obusSPACE = tbl[i].sp;
      obusADDR = tbl[i].a; obusDATA = tbl[i].d;
      ifc.busWR = tbl[i].bw; ifc.busADDR = tbl[i].ba;
      ifc.busBE = tbl[i].be; ifc.busDATA = tbl[i].bd;
      dmaDONE = tbl[i].done; dmaNXM = tbl[i].nxm;
      dmaRDATA = tbl[i].rd;
      cycle();
      chk($sformatf("vec%0d", i), get_out(tbl[i].sel),
          tbl[i].exp);
    end

    // XREG strobe is exactly one cycle wide
    idle();
    cycle();
    chk("lui_pulse_gone", {15'h0, luiWR}, 16'h0);

    // asynchronous reset mid-transfer, between clock edges
    obusWE = 1; obusSPACE = 1; obusADDR = 8;
    obusDATA = 8'h01;
    cycle();
    chk("req_before_rst", {15'h0, dmaREQ}, 16'h1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("req_async_rst", {15'h0, dmaREQ}, 16'h0);
    check_all();
    #3 rst_n = 1'b1;

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      obusWE = 1'($urandom);
      obusSPACE = 1'($urandom);
      obusADDR = 4'($urandom);
      obusDATA = 8'($urandom);
      ifc.busWR = ($urandom % 3) == 0;
      ifc.busADDR = 2'($urandom);
      ifc.busBE = 2'($urandom);
      ifc.busDATA = 16'($urandom);
      dmaDONE = ($urandom % 6) == 0;
      dmaNXM = ($urandom % 10) == 0;
      dmaRDATA = 16'($urandom);
      cycle();
    end
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/kmc_obus.md
# kmc_obus

KMC11 destination-side register file: `kmc_obus` accepts the byte-wide ALU result at the end of each microinstruction and writes it into the selected OBUS/OBUSS destination register. Destinations are the NPR data and address registers, the four CSR words, NPRC, MISC and the LUI (XREG) bus. It holds these registers, feeds them back to the DMUX source mux, and manages the NPR request/done handshake. The Unibus slave interface writes the CSRs through a second port, with a defined collision priority.

## Interface

- No parameters.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- obusWE  in  1  microcode destination write strobe, one cycle per microinstruction
- obusSPACE  in  1  0 = OBUS space (NPR/XREG), 1 = OBUSS space (CSR/NPRC/MISC)
- obusADDR  in  4  destination select within the space
- obusDATA  in  8  ALU result byte
- busWR  in  1  Unibus CSR write strobe
- busADDR  in  2  Unibus CSR word (0..3 → CSR0/2/4/6)
- busBE  in  2  Unibus byte enables, [0] = low byte
- busDATA  in  16  Unibus write data
- dmaDONE  in  1  one-cycle pulse, NPR transfer complete
- dmaNXM  in  1  one-cycle pulse, NPR transfer timed out
- dmaRDATA  in  16  NPR read data, latched on dmaDONE when NPRC[1]=0 (input direction)
- kmcNPRID, kmcNPROD, kmcNPRIA, kmcNPROA  out  16 each  NPR registers
- kmcCSR0, kmcCSR2, kmcCSR4, kmcCSR6  out  16 each  CSR words
- kmcNPRC  out  8  DMA control: [0] request, [1] direction (1 = out), [3:2] address bits 17:16, [7] NXM
- kmcMISC  out  8  miscellaneous register
- luiWR  out  1  registered XREG write strobe
- luiADDR  out  3  XREG number
- luiDATA  out  8  XREG data
- dmaREQ  out  1  equals kmcNPRC[0]

## Operation

- OBUS space (obusSPACE=0) address map:
  - 0 → NPRID low, 1 → NPRID high.
  - 2 → NPROD low, 3 → NPROD high.
  - 4 → NPRIA low, 5 → NPRIA high.
  - 6 → NPROA low, 7 → NPROA high.
  - 8..15 → XREG0..7.
- OBUSS space (obusSPACE=1) address map:
  - 0..7 → CSR bytes 0..7, in the order CSR0 low, CSR0 high, CSR2 low, … CSR6 high.
  - 8 → NPRC.
  - 9 → MISC.
  - 10..15 → no effect.
- XREG writes do not touch local state. They produce a one-cycle luiWR with luiADDR = obusADDR[2:0] and luiDATA = obusDATA.
- CSR collision rule: the Unibus write wins per byte lane. A microcode write to a byte lane that the Unibus is writing in the same cycle is discarded. A microcode write to the other lane still takes effect.
- NPRC handshake:
  - A microcode write to NPRC loads all 8 bits. Writing bit0=1 raises dmaREQ.
  - dmaDONE clears bit0.
  - If dmaDONE is 1 and NPRC[1]=0, NPRID loads dmaRDATA.
  - dmaNXM clears bit0 and sets bit7.
  - A microcode NPRC write in the same cycle as dmaDONE or dmaNXM takes priority for all bits. The start of a new request is never lost.
  - An NPRID microcode write in the same cycle as a DONE-driven load: the DONE load wins on both bytes.
- Reset values:
  - All registers 0; luiWR 0; dmaREQ 0.
  - Reset mid-transfer drops dmaREQ immediately (asynchronous).

## Timing

- Every write is registered. The new value is visible on the outputs in the cycle after the write strobe, so the DMUX reads it in the following microinstruction.
- luiWR, luiADDR and luiDATA are registered: one cycle latency, one cycle wide.
- dmaREQ falls the cycle after dmaDONE or dmaNXM.
- Back-to-back writes to the same byte on consecutive cycles are each honoured.
- There are no stalls or backpressure. The block accepts one microcode write and one Unibus write every cycle.

## Structure

- Package `kmc_obus_pkg` holds:
  - the address constants for both spaces;
  - the NPRC bit positions (REQ = 0, DIR = 1, XA = 3:2, NXM = 7).
- Sub-module `kmc_byte_reg`: 16-bit register with two independent byte lanes. Each lane has a microcode write port and a Unibus write port with Unibus priority. It is instantiated four times, for the CSRs.
- NPR registers, NPRC, MISC and the LUI strobe are implemented in the top module.

## Test plan

- Reset: pulse rst_n low asynchronously, mid-clock → all outputs 0 without waiting for a clock edge.
- Microcode write SPACE=1, ADDR=3, DATA=0xA5 → kmcCSR2 = 0xA500 one cycle later; no other register changes.
- CSR collision, same cycle:
  - stimulus: microcode SPACE=1, ADDR=0, DATA=0x11, together with busWR, busADDR=0, busBE=01, busDATA=0x2233; prior CSR0 = 0;
  - required result: kmcCSR0 = 0x0033.
  - Repeat with busBE=10 → kmcCSR0 = 0x2211.
- NPR read transfer:
  - write NPRC=0x01 → dmaREQ=1 next cycle;
  - dmaDONE with dmaRDATA=0xBEEF → kmcNPRID=0xBEEF, dmaREQ=0 next cycle.
- dmaNXM coincident with a microcode NPRC=0x03 write → NPRC = 0x03; bit7 stays clear and dmaREQ stays 1.
- XREG: SPACE=0, ADDR=13, DATA=0x5C → luiWR high for exactly one cycle, luiADDR=5, luiDATA=0x5C; no local register changes.
